gpio_mux_cfg: RTL

- Runtime-configurable successor to the fixed GPIO pin mux between HostMot2 I/O bits/LEDs and the board GPIO headers.
- Supports NUM_CONN header connectors, each 17 iobits + 1 LED.
- Selects STRAIGHT, DB25-adaptor or SAFE mapping through a small Avalon-MM register slave.
- Mode changes go through a tristate/settle sequence so no pin is driven by two sources during a swap; GPIO inputs are synchronised back to hm2.

---
 rtl/gpio_mux_pkg.sv | 41 ++++
 rtl/gpio_mux_cfg_sync2.sv | 31 +++
 rtl/gpio_mux_cfg.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/gpio_mux_pkg.sv
// Shared types and pin-mapping helpers for the runtime-configurable GPIO pin mux.
package gpio_mux_pkg;

  typedef enum logic [1:0] {
    MODE_STRAIGHT = 2'd0,
    MODE_DB25     = 2'd1,
    MODE_SAFE     = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_SWAP   = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_MODE    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_IN_SNAP = 2'd2;

  localparam int unsigned IO_PER_CONN   = 17;
  localparam int unsigned GPIO_PER_CONN = 18;
  localparam int unsigned DB25_LED_PIN  = 1;

  // In-connector pad offset of iobit k on the DB25 adaptor (pairs run downwards from 16).
  function automatic int unsigned db25_pin(input int unsigned k);
    return 16 - 2 * (k / 2) + (k % 2);
  endfunction

  // Global pad index of iobit k of connector c; SAFE uses the straight map for inputs.
  function automatic int unsigned io_pin(input mode_t m, input int unsigned c, input int unsigned k);
    if (m == MODE_DB25) return c * GPIO_PER_CONN + db25_pin(k);
    return c * IO_PER_CONN + k;
  endfunction

  function automatic int unsigned led_pin(input mode_t m, input int unsigned c, input int unsigned io_w);
    if (m == MODE_DB25) return c * GPIO_PER_CONN + DB25_LED_PIN;
    return io_w + c;
  endfunction

endpackage

// File: rtl/gpio_mux_cfg_sync2.sv
// Parametrised-width two-flop synchroniser for asynchronous pad inputs.
module gpio_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  always_comb q = sync_q;

endmodule

// File: rtl/gpio_mux_cfg.sv
// HostMot2 iobit/LED to GPIO header mux with Avalon-MM selectable mapping and tristated mode swaps.
module gpio_mux_cfg
  import gpio_mux_pkg::*;
#(
  parameter int unsigned NUM_CONN     = 2,
  parameter int unsigned DEFAULT_MODE = 1,
  parameter int unsigned SETTLE_CYC   = 16,
  localparam int unsigned GPIO_W = GPIO_PER_CONN * NUM_CONN,
  localparam int unsigned IO_W   = IO_PER_CONN * NUM_CONN,
  localparam int unsigned LED_W  = NUM_CONN
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  input  logic [IO_W-1:0]   hm2_out,
  input  logic [IO_W-1:0]   hm2_oe,
  output logic [IO_W-1:0]   hm2_in,
  input  logic [LED_W-1:0]  hm2_leds,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_oe,
  input  logic [GPIO_W-1:0] gpio_in
);

  localparam int unsigned GI_W = $clog2(GPIO_W);
  localparam int unsigned II_W = $clog2(IO_W);
  localparam int unsigned LI_W = (LED_W > 1) ? $clog2(LED_W) : 1;
  localparam mode_t       DEF_MODE  = mode_t'(DEFAULT_MODE[1:0]);
  localparam logic [7:0]  SETTLE_LD = 8'(SETTLE_CYC);

  logic              rst_rel_q;
  state_t            state_q, state_d;
  mode_t             cur_mode_q, cur_mode_d;
  mode_t             pend_mode_q, pend_mode_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
  logic [GPIO_W-1:0] gpio_oe_q, gpio_oe_d;
  logic [IO_W-1:0]   hm2_in_q, hm2_in_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [GPIO_W-1:0] gpio_sync;
  logic              busy;
  logic              wdata_unused;

  // Reset asserts asynchronously everywhere but releases on a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_rel_q <= 1'b0;
    else          rst_rel_q <= 1'b1;
  end

  gpio_sync2 #(.WIDTH(GPIO_W)) u_sync (
    .clk     (clk),
    .reset_n (rst_rel_q),
    .d       (gpio_in),
    .q       (gpio_sync)
  );

  assign wdata_unused = ^avs_writedata[31:2];
  assign busy         = (state_q != ST_RUN);

  always_comb begin
    pend_mode_d = pend_mode_q;
    if (avs_write && avs_address == ADDR_MODE && avs_writedata[1:0] != 2'd3)
      pend_mode_d = mode_t'(avs_writedata[1:0]);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_mode_d = cur_mode_q;
    unique case (state_q)
      ST_RUN:    if (pend_mode_q != cur_mode_q) state_d = ST_DRAIN;
      ST_DRAIN: begin
        cnt_d   = SETTLE_LD;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          cnt_d   = '0;
          state_d = ST_SWAP;
        end
      end
      ST_SWAP: begin
        cur_mode_d = pend_mode_q;
        state_d    = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Pads are driven only in cycles whose state is RUN, so keying on the next state
  // blanks the drivers on the same edge the FSM leaves RUN.
  always_comb begin
    gpio_out_d = '0;
    gpio_oe_d  = '0;
    if (state_d == ST_RUN && cur_mode_d != MODE_SAFE) begin
      for (int unsigned c = 0; c < NUM_CONN; c++) begin
        for (int unsigned k = 0; k < IO_PER_CONN; k++) begin
          gpio_out_d[GI_W'(io_pin(cur_mode_d, c, k))] = hm2_out[II_W'(c * IO_PER_CONN + k)];
          gpio_oe_d[GI_W'(io_pin(cur_mode_d, c, k))]  = hm2_oe[II_W'(c * IO_PER_CONN + k)];
        end
        gpio_out_d[GI_W'(led_pin(cur_mode_d, c, IO_W))] = hm2_leds[LI_W'(c)];
        gpio_oe_d[GI_W'(led_pin(cur_mode_d, c, IO_W))]  = 1'b1;
      end
    end
  end

  always_comb begin
    hm2_in_d = '0;
    for (int unsigned c = 0; c < NUM_CONN; c++) begin
      for (int unsigned k = 0; k < IO_PER_CONN; k++) begin
        hm2_in_d[II_W'(c * IO_PER_CONN + k)] = gpio_sync[GI_W'(io_pin(cur_mode_q, c, k))];
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (avs_read) begin
      unique case (avs_address)
        ADDR_MODE:    rdata_d = {30'd0, pend_mode_q};
        ADDR_STATUS:  rdata_d = {8'd0, 8'(NUM_CONN), 7'd0, busy, 6'd0, cur_mode_q};
        ADDR_IN_SNAP: rdata_d = 32'(gpio_sync);
        default:      rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_rel_q) begin
    if (!rst_rel_q) begin
      state_q     <= ST_SETTLE;
      cnt_q       <= SETTLE_LD;
      cur_mode_q  <= MODE_SAFE;
      pend_mode_q <= DEF_MODE;
      gpio_out_q  <= '0;
      gpio_oe_q   <= '0;
      hm2_in_q    <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_mode_q  <= cur_mode_d;
      pend_mode_q <= pend_mode_d;
      gpio_out_q  <= gpio_out_d;
      gpio_oe_q   <= gpio_oe_d;
      hm2_in_q    <= hm2_in_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    gpio_out     = gpio_out_q;
    gpio_oe      = gpio_oe_q;
    hm2_in       = hm2_in_q;
    avs_readdata = rdata_q;
  end

endmodule
